// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//
// Upstream feeder for the 3x3 matrix arithmetic stage. Serial elements arrive
// over a valid/ready handshake and are written row-major into operand A, then
// operand B. Once both are complete the pair is presented on flat buses and
// held stable until the consumer acknowledges with out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   clear      synchronous abort of a partial load or of a held pair
//   in_data    element value (W-bit two's complement, stored bit-exact)
//   in_valid   in_data is valid this cycle
//   in_ready   loader accepts an element this cycle
//   a_flat     matrix A, element (i,j) at bits [(i*N+j)*W +: W]
//   b_flat     matrix B, same packing as a_flat
//   out_valid  a_flat/b_flat hold a complete, stable pair
//   out_ready  consumer takes the pair
//   load_idx   index of the next element to be written (0..2*N*N-1)
//   mat_count  number of pairs delivered, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter  int N     = 3,
  parameter  int W     = 17,
  parameter  int CNT_W = 8,
  localparam int NE    = N * N,
  localparam int IDX_W = $clog2(2 * N * N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [W-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NE*W-1:0]   a_flat,
  output logic [NE*W-1:0]   b_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  load_idx,
  output logic [CNT_W-1:0]  mat_count
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [NE*W-1:0]    a_q,     a_d;
  logic [NE*W-1:0]    b_q,     b_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               accept;

  // in_ready is held low during reset so no element is consumed by a source
  // that is unaware the loader is being reset.
  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      LOAD_A: begin
        if (clear) begin
          idx_d = '0;
        end else if (accept) begin
          // Compare against each constant slot so all part-selects are static.
          for (int e = 0; e < NE; e++) begin
            if (idx_q == IDX_W'(e)) a_d[e*W +: W] = in_data;
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NE - 1)) state_d = LOAD_B;
        end
      end

      LOAD_B: begin
        if (clear) begin
          idx_d   = '0;
          state_d = LOAD_A;
        end else if (accept) begin
          for (int e = 0; e < NE; e++) begin
            if (idx_q == IDX_W'(NE + e)) b_d[e*W +: W] = in_data;
          end
          if (idx_q == IDX_W'(2 * NE - 1)) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      FULL: begin
        // clear wins over the handshake: the pair is abandoned, not counted.
        if (clear) begin
          state_d = LOAD_A;
        end else if (out_ready) begin
          state_d = LOAD_A;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      cnt_q   <= '0;
      // NOTE: the operand storage is reset too, because the consumer may watch
      // a_flat/b_flat directly and must see a defined zero after reset.
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign a_flat    = a_q;
  assign b_flat    = b_q;
  assign load_idx  = idx_q;
  assign mat_count = cnt_q;

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
//
// Self-checking bench for matrix_loader. A transaction-level reference model
// (element count, two element arrays, delivered-pair count) is advanced on
// every clock edge from the driven inputs, and every DUT output is compared
// against it one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_matrix_loader;

  localparam int N     = 3;
  localparam int W     = 17;
  localparam int CNT_W = 8;
  localparam int NE    = N * N;
  localparam int IDX_W = $clog2(2 * N * N);
  localparam int TOTAL = 2 * NE;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NE*W-1:0]   a_flat;
  logic [NE*W-1:0]   b_flat;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  load_idx;
  logic [CNT_W-1:0]  mat_count;

  matrix_loader #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .load_idx  (load_idx),
    .mat_count (mat_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: k = elements taken in the current transaction
  // (TOTAL means the pair is complete and waiting for the consumer).
  // ---------------------------------------------------------------------------
  int          k;
  int          cnt;
  logic [W-1:0] ma [NE];
  logic [W-1:0] mb [NE];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [NE*W-1:0] pack(input logic [W-1:0] m [NE]);
    logic [NE*W-1:0] v = '0;
    for (int e = 0; e < NE; e++) v[e*W +: W] = m[e];
    return v;
  endfunction

  task automatic model_update(input logic r, input logic c, input logic v,
                              input logic [W-1:0] d, input logic ordy);
    if (r) begin
      k   = 0;
      cnt = 0;
      for (int e = 0; e < NE; e++) begin
        ma[e] = '0;
        mb[e] = '0;
      end
    end else if (k == TOTAL) begin
      if (c) k = 0;
      else if (ordy) begin
        k   = 0;
        cnt = (cnt + 1) % (1 << CNT_W);
      end
    end else if (c) begin
      k = 0;
    end else if (v) begin
      if (k < NE) ma[k] = d;
      else        mb[k - NE] = d;
      k++;
    end
  endtask

  task automatic check_outputs();
    check("in_ready",  {159'd0, in_ready},  {159'd0, (!rst && k < TOTAL)});
    check("out_valid", {159'd0, out_valid}, {159'd0, (k == TOTAL)});
    check("load_idx",  160'(load_idx),  160'((k == TOTAL) ? 0 : k));
    check("mat_count", 160'(mat_count), 160'(cnt));
    check("a_flat",    160'(a_flat),    160'(pack(ma)));
    check("b_flat",    160'(b_flat),    160'(pack(mb)));
  endtask

  // One clock cycle: apply inputs, advance model on the edge, compare after.
  task automatic cyc(input logic r, input logic c, input logic v,
                     input logic [W-1:0] d, input logic ordy);
    rst = r; clear = c; in_valid = v; in_data = d; out_ready = ordy;
    @(posedge clk);
    model_update(r, c, v && !r && k < TOTAL, d, ordy);
    #1;
    check_outputs();
  endtask

  function automatic logic [W-1:0] rnd_elem();
    return W'($urandom);
  endfunction

  // Stream elements until the model reports a full pair (bounded).
  task automatic load_pair(input bit bubbles);
    int guard = 0;
    while (k < TOTAL && guard < 400) begin
      cyc(1'b0, 1'b0, bubbles ? 1'($urandom_range(0, 1)) : 1'b1, rnd_elem(), 1'b0);
      guard++;
    end
    check("load_done", {159'd0, out_valid}, {159'd0, 1'b1});
  endtask

  task automatic ack();
    cyc(1'b0, 1'b0, 1'b0, rnd_elem(), 1'b1);
  endtask

  int a_vals [NE] = '{-1, 5, 3, 2, 1, 4, 9, 6, 11};
  int b_vals [NE] = '{22, 12, 3, 6, 8, 7, 19, 3, 8};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt_before;
    k = 0;
    cnt = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b1, rnd_elem(), 1'b0);
    cyc(1'b1, 1'b0, 1'b1, rnd_elem(), 1'b0);
    check("reset_in_ready", {159'd0, in_ready}, 160'd0);

    // Basic load with the fixed operand stream
    for (int i = 0; i < NE; i++) cyc(1'b0, 1'b0, 1'b1, W'(a_vals[i]), 1'b0);
    for (int i = 0; i < NE; i++) cyc(1'b0, 1'b0, 1'b1, W'(b_vals[i]), 1'b0);
    check("basic_a00", 160'(a_flat[0 +: W]),         160'(17'h1FFFF));
    check("basic_a22", 160'(a_flat[8*W +: W]),       160'(17'd11));
    check("basic_b20", 160'(b_flat[(2*N+0)*W +: W]), 160'(17'd19));
    check("basic_rdy", {159'd0, in_ready},           160'd0);

    // Hold while the consumer stalls, then acknowledge
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, rnd_elem(), 1'b0);
    ack();
    check("ack_count", 160'(mat_count), 160'(8'd1));
    check("ack_ready", {159'd0, in_ready}, {159'd0, 1'b1});

    // Bubbles on in_valid
    load_pair(1'b1);
    ack();

    // clear inside B with an element presented
    while (k < 11) cyc(1'b0, 1'b0, 1'b1, rnd_elem(), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, rnd_elem(), 1'b0);
    check("clear_idx", 160'(load_idx), 160'd0);
    load_pair(1'b0);
    ack();

    // Synchronous reset while holding a pair
    load_pair(1'b0);
    cyc(1'b1, 1'b0, 1'b0, rnd_elem(), 1'b0);
    check("rst_full_valid", {159'd0, out_valid}, 160'd0);
    check("rst_full_a",     160'(a_flat),        160'd0);
    check("rst_full_cnt",   160'(mat_count),     160'd0);

    // 256 transactions wrap the counter
    for (int t = 0; t < 256; t++) begin
      load_pair(t[0]);
      ack();
    end
    check("wrap_cnt", 160'(mat_count), 160'd0);

    // clear and out_ready together while holding
    load_pair(1'b1);
    cnt_before = cnt;
    cyc(1'b0, 1'b1, 1'b0, rnd_elem(), 1'b1);
    check("clr_ack_cnt",   160'(mat_count), 160'(cnt_before));
    check("clr_ack_valid", {159'd0, out_valid}, 160'd0);

    // Fully random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 3) != 0), rnd_elem(),
          1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
